// File: rtl/invntt_if.sv
// invntt_if: start/status handshake plus the poly RAM and zeta ROM ports of the
// inverse NTT engine. The engine side is the master: it owns the RAM/ROM bus.
interface invntt_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        r1_en;
  logic [7:0]  r1_addr;
  logic [15:0] r1_d;
  logic        r2_en;
  logic [7:0]  r2_addr;
  logic [15:0] r2_d;
  logic        w1_en;
  logic [7:0]  w1_addr;
  logic [15:0] w1_d;
  logic        w2_en;
  logic [7:0]  w2_addr;
  logic [15:0] w2_d;
  logic [6:0]  zeta_addr;
  logic [15:0] zeta_d;

  modport master (
    input  start,
    output busy, done,
    output r1_en, r1_addr, input r1_d,
    output r2_en, r2_addr, input r2_d,
    output w1_en, w1_addr, w1_d,
    output w2_en, w2_addr, w2_d,
    output zeta_addr, input zeta_d
  );

  modport slave (
    output start,
    input  busy, done,
    input  r1_en, r1_addr, output r1_d,
    input  r2_en, r2_addr, output r2_d,
    input  w1_en, w1_addr, w1_d,
    input  w2_en, w2_addr, w2_d,
    input  zeta_addr, output zeta_d
  );
endinterface

// File: rtl/invntt.sv
// invntt: Kyber inverse NTT (q=3329, n=256), in place on an external dual-port RAM.
// Seven Gentleman-Sande layers (len=2..128) followed by a scaling pass by 1441.
// One butterfly (or scale pair) is issued per cycle; results are written 4 cycles later.
module invntt (
  input  logic     i_clk,
  input  logic     i_rst_n,
  invntt_if.master bus
);
  localparam int unsigned N             = 256;
  localparam logic [7:0]  IssuesPerPass = 8'(N / 2);
  localparam logic [7:0]  LastLen       = 8'd128;
  localparam logic [1:0]  DrainLast     = 2'd3;
  localparam logic signed [31:0] Q      = 32'sd3329;
  localparam logic signed [31:0] Qinv   = 32'sd62209;
  localparam logic signed [31:0] BarV   = 32'sd20159;
  localparam logic signed [15:0] FTom   = 16'sd1441;

  typedef enum logic [2:0] {StIdle, StLayer, StDrain, StScale, StSdrain, StDone} state_e;

  // Montgomery reduction of a 32-bit product, bit exact with the C reference.
  function automatic logic signed [15:0] fq_reduce(input logic signed [31:0] p);
    logic signed [31:0] m;
    logic signed [31:0] u;
    logic signed [31:0] t;
    m = p * Qinv;
    u = {{16{m[15]}}, m[15:0]};
    t = p - u * Q;
    return t[31:16];
  endfunction

  // Barrett reduction of an int16 to a small representative.
  function automatic logic signed [15:0] barrett(input logic signed [15:0] a);
    logic signed [31:0] a32;
    logic signed [31:0] t;
    logic signed [31:0] r;
    a32 = {{16{a[15]}}, a};
    t   = (BarV * a32 + 32'sd33554432) >>> 26;
    r   = a32 - t * Q;
    return r[15:0];
  endfunction

  // Control state
  state_e     r_state;
  logic [7:0] r_idx;
  logic [7:0] r_len;
  logic [1:0] r_drain;
  logic       r_busy;
  logic       r_done;

  // Read-issue registers
  logic       r_ren;
  logic       r_rd_sc;
  logic [7:0] r_rd_lo;
  logic [7:0] r_rd_hi;
  logic [6:0] r_zeta_addr;
  logic [6:0] r_k;

  // Issue decode
  logic       w_issue;
  logic [6:0] w_iss_idx;
  logic [7:0] w_iss_len;
  logic [6:0] w_iss_k;
  logic       w_iss_sc;
  logic [7:0] w_mask;
  logic [7:0] w_idx8;
  logic       w_grp_end;
  logic [7:0] w_lo;
  logic [7:0] w_hi;

  // Pipeline
  logic              r_v0, r_v1, r_v2, r_wen;
  logic              r_sc0, r_sc1, r_sc2;
  logic [7:0]        r_lo_a0, r_hi_a0, r_lo_a1, r_hi_a1, r_lo_a2, r_hi_a2, r_w_lo_a, r_w_hi_a;
  logic signed [15:0] r_lo1, r_op1, r_z1, r_lo2;
  logic signed [31:0] r_phi2, r_plo2;
  logic signed [15:0] r_w_d_lo, r_w_d_hi;
  logic signed [15:0] w_a_lo, w_a_hi, w_zeta, w_sum, w_diff;
  logic signed [31:0] w_mul_hi, w_mul_lo;

  // Decide whether a read is issued at the next edge, and for which index/len/k.
  always_comb begin
    w_issue   = 1'b0;
    w_iss_idx = r_idx[6:0];
    w_iss_len = r_len;
    w_iss_k   = r_k;
    w_iss_sc  = (r_state == StScale);
    unique case (r_state)
      StIdle, StDone: begin
        w_issue   = bus.start;
        w_iss_idx = 7'd0;
        w_iss_len = 8'd2;
        w_iss_k   = 7'd127;
      end
      StLayer, StScale: w_issue = (r_idx != IssuesPerPass);
      StDrain: begin
        // The next pass starts the cycle after the last write of this one.
        w_issue   = (r_drain == DrainLast);
        w_iss_idx = 7'd0;
        if (r_len == LastLen) w_iss_sc = 1'b1;
        else                  w_iss_len = r_len << 1;
      end
      default: ;
    endcase
  end

  assign w_mask    = w_iss_len - 8'd1;
  assign w_idx8    = {1'b0, w_iss_idx};
  assign w_grp_end = ((w_idx8 & w_mask) == w_mask);

  // Map butterfly index to (j, j+len): group bits shift up by one, offset bits stay.
  always_comb begin
    if (w_iss_sc) begin
      w_lo = {w_iss_idx, 1'b0};
      w_hi = {w_iss_idx, 1'b1};
    end else begin
      w_lo = ((w_idx8 & ~w_mask) << 1) | (w_idx8 & w_mask);
      w_hi = w_lo + w_iss_len;
    end
  end

  // Control FSM: pass sequencing, busy and done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idx   <= 8'd0;
      r_len   <= 8'd2;
      r_drain <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            r_state <= StLayer;
            r_idx   <= 8'd1;
            r_len   <= 8'd2;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= StIdle;
          end
        end
        StLayer, StScale: begin
          if (r_idx == IssuesPerPass) begin
            r_state <= (r_state == StLayer) ? StDrain : StSdrain;
            r_drain <= 2'd0;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        StDrain: begin
          if (r_drain == DrainLast) begin
            r_idx <= 8'd1;
            if (r_len == LastLen) begin
              r_state <= StScale;
            end else begin
              r_state <= StLayer;
              r_len   <= r_len << 1;
            end
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        StSdrain: begin
          if (r_drain == DrainLast) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Registered read addresses, zeta index and the running k.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ren       <= 1'b0;
      r_rd_sc     <= 1'b0;
      r_rd_lo     <= 8'd0;
      r_rd_hi     <= 8'd0;
      r_zeta_addr <= 7'd0;
      r_k         <= 7'd127;
    end else begin
      r_ren <= w_issue;
      if (w_issue) begin
        r_rd_sc <= w_iss_sc;
        r_rd_lo <= w_lo;
        r_rd_hi <= w_hi;
        if (w_iss_sc) begin
          r_zeta_addr <= 7'd0;
        end else begin
          r_zeta_addr <= w_iss_k;
          r_k         <= w_grp_end ? w_iss_k - 7'd1 : w_iss_k;
        end
      end
    end
  end

  assign w_a_lo   = bus.r2_d;
  assign w_a_hi   = bus.r1_d;
  assign w_zeta   = bus.zeta_d;
  assign w_sum    = w_a_lo + w_a_hi;
  assign w_diff   = w_a_hi - w_a_lo;
  assign w_mul_hi = {{16{r_z1[15]}}, r_z1} * {{16{r_op1[15]}}, r_op1};
  assign w_mul_lo = {{16{FTom[15]}}, FTom} * {{16{r_lo1[15]}}, r_lo1};

  // Datapath: RAM/ROM data, add/sub+barrett, multiply, reduce/write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v0 <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0; r_wen <= 1'b0;
      r_sc0 <= 1'b0; r_sc1 <= 1'b0; r_sc2 <= 1'b0;
      r_lo_a0 <= 8'd0; r_hi_a0 <= 8'd0; r_lo_a1 <= 8'd0; r_hi_a1 <= 8'd0;
      r_lo_a2 <= 8'd0; r_hi_a2 <= 8'd0; r_w_lo_a <= 8'd0; r_w_hi_a <= 8'd0;
      r_lo1 <= 16'sd0; r_op1 <= 16'sd0; r_z1 <= 16'sd0; r_lo2 <= 16'sd0;
      r_phi2 <= 32'sd0; r_plo2 <= 32'sd0;
      r_w_d_lo <= 16'sd0; r_w_d_hi <= 16'sd0;
    end else begin
      r_v0    <= r_ren;
      r_sc0   <= r_rd_sc;
      r_lo_a0 <= r_rd_lo;
      r_hi_a0 <= r_rd_hi;

      r_v1    <= r_v0;
      r_sc1   <= r_sc0;
      r_lo_a1 <= r_lo_a0;
      r_hi_a1 <= r_hi_a0;
      r_lo1   <= r_sc0 ? w_a_lo : barrett(w_sum);
      r_op1   <= r_sc0 ? w_a_hi : w_diff;
      r_z1    <= r_sc0 ? FTom : w_zeta;

      r_v2    <= r_v1;
      r_sc2   <= r_sc1;
      r_lo_a2 <= r_lo_a1;
      r_hi_a2 <= r_hi_a1;
      r_phi2  <= w_mul_hi;
      r_plo2  <= w_mul_lo;
      r_lo2   <= r_lo1;

      r_wen    <= r_v2;
      r_w_lo_a <= r_lo_a2;
      r_w_hi_a <= r_hi_a2;
      r_w_d_hi <= fq_reduce(r_phi2);
      r_w_d_lo <= r_sc2 ? fq_reduce(r_plo2) : r_lo2;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.r1_en     = r_ren;
  assign bus.r1_addr   = r_rd_hi;
  assign bus.r2_en     = r_ren;
  assign bus.r2_addr   = r_rd_lo;
  assign bus.zeta_addr = r_zeta_addr;
  assign bus.w1_en     = r_wen;
  assign bus.w1_addr   = r_w_hi_a;
  assign bus.w1_d      = r_w_d_hi;
  assign bus.w2_en     = r_wen;
  assign bus.w2_addr   = r_w_lo_a;
  assign bus.w2_d      = r_w_d_lo;
endmodule

// File: tb/tb_invntt.sv
// tb_invntt: scoreboard bench for invntt. A C-style golden model predicts every
// write (address and data) and every zeta index; a negedge monitor pops and compares.
module tb_invntt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  invntt_if bus ();
  invntt u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  localparam logic signed [15:0] ZETAS [128] = '{
    -1044, -758, -359, -1517, 1493, 1422, 287, 202,
    -171, 622, 1577, 182, 962, -1202, -1474, 1468,
    573, -1325, 264, 383, -829, 1458, -1602, -130,
    -681, 1017, 732, 608, -1542, 411, -205, -1571,
    1223, 652, -552, 1015, -1293, 1491, -282, -1544,
    516, -8, -320, -666, -1618, -1162, 126, 1469,
    -853, -90, -271, 830, 107, -1421, -247, -951,
    -398, 961, -1508, -725, 448, -1065, 677, -1275,
    -1103, 430, 555, 843, -1251, 871, 1550, 105,
    422, 587, 177, -235, -291, -460, 1574, 1653,
    -246, 778, 1159, -147, -777, 1483, -602, 1119,
    -1590, 644, -872, 349, 418, 329, -156, -75,
    817, 1097, 603, 610, 1322, -1285, -1465, 384,
    -1215, -136, 1218, -1335, -874, 220, -1187, -1659,
    -1185, -1530, -1278, 794, -1510, -854, -870, 478,
    -108, -308, 996, 991, 958, -1460, 1522, 1628
  };

  typedef struct {
    int          a_lo;
    int          a_hi;
    logic [15:0] d_lo;
    logic [15:0] d_hi;
  } wr_t;

  wr_t exp_q[$];
  int  exp_z[$];
  int  model[256];
  logic signed [15:0] mem [256];
  int  n_checks = 0;
  int  n_errors = 0;
  int  pe_cnt = 0;
  int  base = 0;
  int  load_mode = 0;
  logic load_go = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int init_val(input int mode, input int i);
    case (mode)
      1:       return (i == 0) ? 1 : 0;
      2:       return ((i * 37) % 3329) - 1664;
      3:       return (i % 2 == 0) ? (3000 - i) : (i - 3000);
      default: return 0;
    endcase
  endfunction

  function automatic int m_fqmul(input int a, input int b);
    int p, u, t;
    p = a * b;
    u = int'(shortint'(p * 62209));
    t = (p - u * 3329) >>> 16;
    return int'(shortint'(t));
  endfunction

  function automatic int m_barrett(input int a);
    int t;
    t = (20159 * a + (1 << 25)) >>> 26;
    return int'(shortint'(a - t * 3329));
  endfunction

  // Golden invntt_tomont; records writes in issue order.
  task automatic build_expected();
    int k, t, zeta;
    wr_t e;
    k = 127;
    for (int len = 2; len <= 128; len = len << 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        zeta = int'(ZETAS[k]);
        for (int j = st; j < st + len; j++) begin
          t = model[j];
          model[j] = m_barrett(int'(shortint'(t + model[j + len])));
          model[j + len] = m_fqmul(zeta, int'(shortint'(model[j + len] - t)));
          e.a_lo = j; e.a_hi = j + len;
          e.d_lo = 16'(model[j]); e.d_hi = 16'(model[j + len]);
          exp_q.push_back(e);
          exp_z.push_back(k);
        end
        k--;
      end
    end
    for (int m = 0; m < 128; m++) begin
      model[2 * m]     = m_fqmul(model[2 * m], 1441);
      model[2 * m + 1] = m_fqmul(model[2 * m + 1], 1441);
      e.a_lo = 2 * m; e.a_hi = 2 * m + 1;
      e.d_lo = 16'(model[2 * m]); e.d_hi = 16'(model[2 * m + 1]);
      exp_q.push_back(e);
      exp_z.push_back(-1);
    end
  endtask

  always @(posedge clk) pe_cnt <= pe_cnt + 1;

  // RAM and zeta ROM models, 1-cycle read latency.
  always @(posedge clk) begin
    if (load_go) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(init_val(load_mode, i));
    end else begin
      if (bus.w1_en) mem[bus.w1_addr] <= bus.w1_d;
      if (bus.w2_en) mem[bus.w2_addr] <= bus.w2_d;
    end
    if (bus.r1_en) bus.r1_d <= mem[bus.r1_addr];
    if (bus.r2_en) bus.r2_d <= mem[bus.r2_addr];
    bus.zeta_d <= ZETAS[bus.zeta_addr];
  end

  // Monitor: pops expectations whenever the DUT reads or writes.
  logic       h_en [4] = '{default: 1'b0};
  logic [7:0] h_a1 [4] = '{default: 8'd0};
  logic [7:0] h_a2 [4] = '{default: 8'd0};
  always @(negedge clk) begin : mon
    int  z;
    wr_t e;
    if (!rst_n) begin
      chk("no_write_in_reset", {bus.w1_en, bus.w2_en}, 0);
      for (int i = 0; i < 4; i++) h_en[i] <= 1'b0;
    end else begin
      if (bus.r1_en || bus.r2_en) begin
        if (exp_z.size() == 0) chk("unexpected_read_qsize", exp_z.size(), 1);
        else begin
          z = exp_z.pop_front();
          if (z >= 0) chk("zeta_addr", bus.zeta_addr, z);
        end
      end
      if (bus.w1_en || bus.w2_en) begin
        chk("w_en_pair", {bus.w1_en, bus.w2_en}, 2'b11);
        chk("w_lag_rd_en", h_en[3], 1);
        chk("w1_addr_lag", bus.w1_addr, h_a1[3]);
        chk("w2_addr_lag", bus.w2_addr, h_a2[3]);
        if (exp_q.size() == 0) chk("unexpected_write_qsize", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("w2_addr", bus.w2_addr, e.a_lo);
          chk("w1_addr", bus.w1_addr, e.a_hi);
          chk("w2_data", bus.w2_d, e.d_lo);
          chk("w1_data", bus.w1_d, e.d_hi);
        end
      end
      if (bus.r1_en && bus.w1_en) chk("rw_same_addr_p1", bus.r1_addr != bus.w1_addr, 1);
      if (bus.r2_en && bus.w2_en) chk("rw_same_addr_p2", bus.r2_addr != bus.w2_addr, 1);
      h_en[0] <= bus.r1_en;
      h_a1[0] <= bus.r1_addr;
      h_a2[0] <= bus.r2_addr;
      for (int i = 1; i < 4; i++) begin
        h_en[i] <= h_en[i - 1];
        h_a1[i] <= h_a1[i - 1];
        h_a2[i] <= h_a2[i - 1];
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {bus.busy, bus.done, bus.r1_en, bus.r2_en, bus.w1_en, bus.w2_en}, 0);
    chk({tag, "_addr"}, {bus.r1_addr, bus.r2_addr, bus.w1_addr, bus.w2_addr, bus.zeta_addr}, 0);
    chk({tag, "_data"}, {bus.w1_d, bus.w2_d}, 0);
  endtask

  task automatic load_and_model(input int mode);
    @(negedge clk);
    load_mode = mode;
    load_go   = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = init_val(mode, i);
    build_expected();
  endtask

  task automatic run_full(input int mode, input int extra_at, input string tag);
    int   c;
    logic busy_last;
    busy_last = 1'b0;
    load_and_model(mode);
    @(negedge clk);
    bus.start = 1'b1;
    base = pe_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    c = pe_cnt - base;
    chk({tag, "_busy_c1"}, bus.busy, 1);
    chk({tag, "_done_cleared"}, bus.done, 0);
    while (!bus.done && c < 1200) begin
      @(negedge clk);
      c = pe_cnt - base;
      bus.start = (c == extra_at);
      if (c == 1056) busy_last = bus.busy;
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, c, 1057);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_busy_c1056"}, busy_last, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_level"}, bus.done, 1);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, exp_z.size(), 0);
    for (int i = 0; i < 256; i++) chk({tag, "_ram"}, mem[i], model[i]);
  endtask

  task automatic run_abort(input int mode, input int at);
    load_and_model(mode);
    @(negedge clk);
    bus.start = 1'b1;
    base = pe_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    while ((pe_cnt - base) < at) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort_reset");
    exp_q.delete();
    exp_z.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    #3 check_outputs_zero("por_reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_full(0, -1, "zero");
    run_full(1, -1, "impulse");
    run_full(2, -1, "ramp");
    run_full(3, -1, "large");
    run_full(1, 500, "restart_ignored");
    run_abort(2, 300);
    run_full(1, -1, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
